move_scheduler: RTL

Per-frame movement sequencer for the sprite layer. It time-shares one step/clamp/wrap datapath across the player sprite (object 0) and N_NPC autonomous horizontal movers (objects 1..N_NPC). On each frame_tick it sweeps the objects, updating one object per clock. It sits between the keyboard decoder / VGA timing and the sprite renderer.

---
 rtl/move_scheduler_pkg.sv | 33 +++
 rtl/move_scheduler_if.sv | 32 +++
 rtl/move_scheduler_step.sv | 43 ++++
 rtl/move_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the sprite movement scheduler.
// Holds the position width, default screen bounds, the sweep FSM encoding,
// the step-unit operating modes and the bit positions of the latched keys.
package move_pkg;

  localparam int POS_W  = 10;
  localparam int CALC_W = POS_W + 1;  // one spare bit so sums never wrap

  localparam int DEF_H_MIN = 20;
  localparam int DEF_H_MAX = 319;
  localparam int DEF_V_MIN = 20;
  localparam int DEF_V_MAX = 239;

  // Bit positions inside the latched key vector {a, d, w, s}
  localparam int KEY_A = 3;
  localparam int KEY_D = 2;
  localparam int KEY_W = 1;
  localparam int KEY_S = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD      = 2'd0,
    MODE_INC_CLAMP = 2'd1,
    MODE_DEC_CLAMP = 2'd2,
    MODE_INC_WRAP  = 2'd3
  } step_mode_t;

endpackage

// File: rtl/move_scheduler_if.sv
// Bundle between the scheduler and its surroundings (keyboard decoder,
// VGA frame timing, sprite renderer).
//   master: drives frame_tick and key_a/d/w/s, reads positions and status
//   slave : the scheduler itself
//   pos_h_m packs mover i into bits [10i+9:10i]
interface move_scheduler_if
  import move_pkg::*;
#(
  parameter int N_NPC = 4
);
  logic                   frame_tick;
  logic                   key_a;
  logic                   key_d;
  logic                   key_w;
  logic                   key_s;
  logic [POS_W-1:0]       pos_h;
  logic [POS_W-1:0]       pos_v;
  logic [POS_W*N_NPC-1:0] pos_h_m;
  logic                   busy;
  logic                   sweep_done;
  logic                   overrun;

  modport master (
    output frame_tick, key_a, key_d, key_w, key_s,
    input  pos_h, pos_v, pos_h_m, busy, sweep_done, overrun
  );

  modport slave (
    input  frame_tick, key_a, key_d, key_w, key_s,
    output pos_h, pos_v, pos_h_m, busy, sweep_done, overrun
  );
endinterface

// File: rtl/move_scheduler_step.sv
// Shared step/clamp/wrap datapath, purely combinational.
//   pos      : current position
//   mode     : hold / increment-clamp / decrement-clamp / increment-wrap
//   lo, hi   : bounds for the object being updated
//   step     : pixels per frame
//   pos_next : updated position
module move_step_unit
  import move_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  step_mode_t       mode,
  input  logic [POS_W-1:0] lo,
  input  logic [POS_W-1:0] hi,
  input  logic [POS_W-1:0] step,
  output logic [POS_W-1:0] pos_next
);

  logic [CALC_W-1:0] pos_w;
  logic [CALC_W-1:0] hi_w;
  logic [CALC_W-1:0] sum_w;
  logic [CALC_W-1:0] lo_plus_w;

  assign pos_w     = {1'b0, pos};
  assign hi_w      = {1'b0, hi};
  assign sum_w     = pos_w + {1'b0, step};
  // Decrement clamp compares against lo+step so the subtraction never underflows
  assign lo_plus_w = {1'b0, lo} + {1'b0, step};

  always_comb begin
    pos_next = pos;
    case (mode)
      MODE_INC_CLAMP: pos_next = (sum_w > hi_w) ? hi : sum_w[POS_W-1:0];
      MODE_DEC_CLAMP: pos_next = (pos_w < lo_plus_w) ? lo : (pos - step);
      MODE_INC_WRAP: begin
        if (pos_w >= hi_w)     pos_next = lo;
        else if (sum_w > hi_w) pos_next = hi;
        else                   pos_next = sum_w[POS_W-1:0];
      end
      default: pos_next = pos;
    endcase
  end

endmodule

// File: rtl/move_scheduler.sv
// Per-frame movement sequencer. On each frame_tick it sweeps the player
// (object 0) and N_NPC horizontal movers (objects 1..N_NPC) through one
// shared step unit, one object per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : move_scheduler_if.slave (tick, keys, positions, status)
//
// state | meaning
// IDLE  | waiting for frame_tick or a pending tick; latches keys on start
// SWEEP | writes object idx, idx 0 = player, idx k = mover k
// DONE  | sweep_done pulse, back to IDLE next cycle
module move_scheduler
  import move_pkg::*;
#(
  parameter int N_NPC     = 4,
  parameter int STEP      = 1,
  parameter int H_MIN     = DEF_H_MIN,
  parameter int H_MAX     = DEF_H_MAX,
  parameter int V_MIN     = DEF_V_MIN,
  parameter int V_MAX     = DEF_V_MAX,
  parameter int P_H_RST   = 20,
  parameter int P_V_RST   = 20,
  parameter int NPC_H_RST = 20
) (
  input logic             clk,
  input logic             rst,
  move_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(N_NPC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NPC);

  localparam logic [POS_W-1:0] STEP_L  = POS_W'(STEP);
  localparam logic [POS_W-1:0] H_MIN_L = POS_W'(H_MIN);
  localparam logic [POS_W-1:0] H_MAX_L = POS_W'(H_MAX);
  localparam logic [POS_W-1:0] V_MIN_L = POS_W'(V_MIN);
  localparam logic [POS_W-1:0] V_MAX_L = POS_W'(V_MAX);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       keys_q;
  logic             pending;
  logic             overrun_q;
  logic             busy_q;
  logic             done_q;
  logic [POS_W-1:0] pos_h_q;
  logic [POS_W-1:0] pos_v_q;
  logic [POS_W-1:0] npc_q [N_NPC];

  logic [POS_W-1:0] dp_pos;
  logic [POS_W-1:0] dp_lo;
  logic [POS_W-1:0] dp_hi;
  logic [POS_W-1:0] dp_next;
  step_mode_t       dp_mode;

  // Operand mux for the shared datapath: player axis by key priority, else mover idx
  always_comb begin
    dp_pos  = pos_h_q;
    dp_lo   = H_MIN_L;
    dp_hi   = H_MAX_L;
    dp_mode = MODE_HOLD;
    if (idx == '0) begin
      if (keys_q[KEY_A]) begin
        dp_mode = MODE_INC_CLAMP;
      end else if (keys_q[KEY_D]) begin
        dp_mode = MODE_DEC_CLAMP;
      end else if (keys_q[KEY_W]) begin
        dp_pos  = pos_v_q;
        dp_lo   = V_MIN_L;
        dp_hi   = V_MAX_L;
        dp_mode = MODE_INC_CLAMP;
      end else if (keys_q[KEY_S]) begin
        dp_pos  = pos_v_q;
        dp_lo   = V_MIN_L;
        dp_hi   = V_MAX_L;
        dp_mode = MODE_DEC_CLAMP;
      end
    end else begin
      dp_mode = MODE_INC_WRAP;
      for (int i = 0; i < N_NPC; i++) begin
        if (idx == IDX_W'(i + 1)) dp_pos = npc_q[i];
      end
    end
  end

  move_step_unit u_step (
    .pos      (dp_pos),
    .mode     (dp_mode),
    .lo       (dp_lo),
    .hi       (dp_hi),
    .step     (STEP_L),
    .pos_next (dp_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      keys_q    <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pos_h_q   <= POS_W'(P_H_RST);
      pos_v_q   <= POS_W'(P_V_RST);
      for (int i = 0; i < N_NPC; i++) npc_q[i] <= POS_W'(NPC_H_RST);
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_tick || pending) begin
            keys_q  <= {bus.key_a, bus.key_d, bus.key_w, bus.key_s};
            pending <= 1'b0;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= SWEEP;
          end
        end
        SWEEP: begin
          if (idx == '0) begin
            if (keys_q[KEY_A] || keys_q[KEY_D])      pos_h_q <= dp_next;
            else if (keys_q[KEY_W] || keys_q[KEY_S]) pos_v_q <= dp_next;
          end
          for (int i = 0; i < N_NPC; i++) begin
            if (idx == IDX_W'(i + 1)) npc_q[i] <= dp_next;
          end
          if (idx == IDX_LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A tick arriving while busy (DONE included) is remembered once; a second one is lost
      if (bus.frame_tick && state != IDLE) begin
        if (pending) overrun_q <= 1'b1;
        else         pending   <= 1'b1;
      end
    end
  end

  assign bus.pos_h      = pos_h_q;
  assign bus.pos_v      = pos_v_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;
  assign bus.overrun    = overrun_q;

  always_comb begin
    bus.pos_h_m = '0;
    for (int i = 0; i < N_NPC; i++) bus.pos_h_m[POS_W*i +: POS_W] = npc_q[i];
  end

endmodule
